// File: rtl/mc_sequencer_pkg.sv
// mc_sequencer_pkg: shared state encodings, exception codes and instruction-class bit order
package mc_sequencer_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXE      = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_MD_ISSUE = 4'd10,
        S_MD_MOVE  = 4'd11,
        S_INT      = 4'd12
    } state_t;

    localparam logic [4:0] EXC_INT_CODE = 5'd0;
    localparam logic [4:0] EXC_DBE_CODE = 5'd7;

    // Bit positions of the pre-decoded class vector, in dispatch priority order
    localparam int CLS_LOAD     = 0;
    localparam int CLS_STORE    = 1;
    localparam int CLS_BRANCH   = 2;
    localparam int CLS_JUMP     = 3;
    localparam int CLS_MD_START = 4;
    localparam int CLS_MD_MOVE  = 5;
    localparam int CLS_W        = 6;

endpackage

// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: decoder/CP0/handshake inputs and datapath/CP0 enables of the sequencer
//   master: drives instruction class, handshakes, irq/CP0 status; observes enables
//   slave : the sequencer side
interface mc_sequencer_if #(
    parameter int NUM_IRQ = 6
);
    logic               cls_load, cls_store, cls_branch, cls_jump, cls_md_start, cls_md_move;
    logic               wb_en, is_eret;
    logic               imem_ready, dmem_ready, md_busy;
    logic [NUM_IRQ-1:0] irq, im;
    logic               ie, exl;
    logic               pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, md_start, md_move;
    logic               epc_wr, exl_set, exl_clr, npc_exc;
    logic [NUM_IRQ-1:0] hw_cause;
    logic [4:0]         exc_code;
    logic [3:0]         state;

    modport master (
        output cls_load, cls_store, cls_branch, cls_jump, cls_md_start, cls_md_move,
        output wb_en, is_eret, imem_ready, dmem_ready, md_busy, irq, im, ie, exl,
        input  pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, md_start, md_move,
        input  epc_wr, exl_set, exl_clr, npc_exc, hw_cause, exc_code, state
    );

    modport slave (
        input  cls_load, cls_store, cls_branch, cls_jump, cls_md_start, cls_md_move,
        input  wb_en, is_eret, imem_ready, dmem_ready, md_busy, irq, im, ie, exl,
        output pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, md_start, md_move,
        output epc_wr, exl_set, exl_clr, npc_exc, hw_cause, exc_code, state
    );
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins one-hot priority encoder
//   req    in  N  request vector
//   onehot out N  lowest set bit of req
//   valid  out 1  any request set
module irq_prio_enc #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         valid
);
    // x & -x isolates the lowest set bit
    assign onehot = req & (~req + N'(1));
    assign valid  = |req;
endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle MIPS controller with memory timeout, mul/div interlock and interrupts
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mc_sequencer_if.slave (class/handshake/CP0 inputs, enables, hw_cause, exc_code, state)
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int         NUM_IRQ     = 6,
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [4:0] EXC_INT     = EXC_INT_CODE,
    parameter logic [4:0] EXC_DBE     = EXC_DBE_CODE
) (
    input logic           clk,
    input logic           rst_n,
    mc_sequencer_if.slave bus
);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t             st;
    logic [CW-1:0]      cnt;
    logic [NUM_IRQ-1:0] cause, pend, pend_oh;
    logic [4:0]         code;
    logic [CLS_W-1:0]   cls;
    logic               pend_v, tmo, done, busy, in_int;

    assign cls = {bus.cls_md_move, bus.cls_md_start, bus.cls_jump,
                  bus.cls_branch, bus.cls_store, bus.cls_load};

    assign pend = bus.irq & bus.im & {NUM_IRQ{bus.ie & ~bus.exl}};

    irq_prio_enc #(.N(NUM_IRQ)) u_enc (.req(pend), .onehot(pend_oh), .valid(pend_v));

    assign tmo    = (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT - 1));
    assign busy   = bus.md_busy;
    assign in_int = st == S_INT;
    assign done   = st == S_MEM_WB || st == S_ALU_WB || st == S_BRANCH || st == S_JUMP
                 || (st == S_MEM_WR && bus.dmem_ready)
                 || ((st == S_MD_ISSUE || st == S_MD_MOVE) && !busy);

    assign bus.pc_wr    = rst_n & (done | in_int);
    assign bus.ir_wr    = rst_n & (st == S_FETCH) & bus.imem_ready;
    assign bus.reg_wr   = rst_n & (st == S_MEM_WB || st == S_ALU_WB
                                   || ((st == S_JUMP || (st == S_MD_MOVE && !busy)) && bus.wb_en));
    assign bus.mem_rd   = rst_n & (st == S_MEM_RD);
    assign bus.mem_wr   = rst_n & (st == S_MEM_WR);
    assign bus.md_start = rst_n & (st == S_MD_ISSUE) & ~busy;
    assign bus.md_move  = rst_n & (st == S_MD_MOVE) & ~busy;
    assign bus.epc_wr   = rst_n & in_int;
    assign bus.exl_set  = rst_n & in_int;
    assign bus.npc_exc  = rst_n & in_int;
    assign bus.exl_clr  = rst_n & (st == S_JUMP) & bus.is_eret;
    assign bus.hw_cause = cause;
    assign bus.exc_code = code;
    assign bus.state    = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= S_FETCH;
            cnt   <= '0;
            cause <= '0;
            code  <= '0;
        end else if (done) begin
            st <= pend_v ? S_INT : S_FETCH;
            if (pend_v) begin
                cause <= pend_oh;
                code  <= EXC_INT;
            end
        end else begin
            case (st)
                S_FETCH:    if (bus.imem_ready) st <= S_DECODE;
                S_DECODE:   st <= (cls[CLS_LOAD] | cls[CLS_STORE]) ? S_MEM_ADDR :
                                  cls[CLS_BRANCH]   ? S_BRANCH   :
                                  cls[CLS_JUMP]     ? S_JUMP     :
                                  cls[CLS_MD_START] ? S_MD_ISSUE :
                                  cls[CLS_MD_MOVE]  ? S_MD_MOVE  : S_EXE;
                S_MEM_ADDR: begin
                    st  <= cls[CLS_LOAD] ? S_MEM_RD : S_MEM_WR;
                    cnt <= '0;
                end
                // MEM_WR with ready is a completion and never reaches here
                S_MEM_RD, S_MEM_WR: begin
                    if (bus.dmem_ready) st <= S_MEM_WB;
                    else if (tmo) begin
                        st    <= S_INT;
                        cause <= '0;
                        code  <= EXC_DBE;
                    end else cnt <= cnt + CW'(1);
                end
                S_EXE:                 st <= S_ALU_WB;
                S_MD_ISSUE, S_MD_MOVE: st <= st;
                default:               st <= S_FETCH;
            endcase
        end
    end
endmodule
